// File: rtl/npu_layer_sequencer.sv
// Layer-pass controller: load A from RAM, run the MAC array, Leaky ReLU, normalize, store result.
// The raw start button is synchronized and edge-detected into a single-cycle trigger.
module npu_layer_sequencer #(
   parameter int N           = 10,
   parameter int ADDR_W      = 16,
   parameter int ACT_LAT     = 1,
   parameter int NORM_LAT    = 2,
   parameter int MAC_TIMEOUT = 1023
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_btn,
   input  logic [ADDR_W-1:0] src_base,
   input  logic [ADDR_W-1:0] dst_base,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_en,
   input  logic              mem_rd_valid,
   output logic              mem_wr_en,
   output logic [3:0]        elem_row,
   output logic [3:0]        elem_col,
   output logic              load_we,
   output logic              mac_start,
   input  logic              mac_done,
   output logic              act_en,
   output logic              norm_en,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [2:0]        state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_MAC   = 3'd2,
      S_ACT   = 3'd3,
      S_NORM  = 3'd4,
      S_STORE = 3'd5,
      S_DONE  = 3'd6
   } state_t;

   localparam int CNT_MAX = (MAC_TIMEOUT > ACT_LAT)
                          ? ((MAC_TIMEOUT > NORM_LAT) ? MAC_TIMEOUT : NORM_LAT)
                          : ((ACT_LAT > NORM_LAT) ? ACT_LAT : NORM_LAT);
   localparam int CNT_W = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0]  MAC_LAST  = CNT_W'(MAC_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]  ACT_LAST  = CNT_W'(ACT_LAT - 1);
   localparam logic [CNT_W-1:0]  NORM_LAST = CNT_W'(NORM_LAT - 1);
   localparam logic [3:0]        IDX_LAST  = 4'(N - 1);
   localparam logic [ADDR_W-1:0] N_A       = ADDR_W'(N);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   src_q, src_d;
   logic [ADDR_W-1:0]   dst_q, dst_d;
   logic [3:0]          row_q, row_d;
   logic [3:0]          col_q, col_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                mac_first_q, mac_first_d;
   logic                error_q, error_d;
   logic                btn_meta_q, btn_sync_q, btn_prev_q;

   logic                trigger;
   logic                last_elem;
   logic [3:0]          adv_row, adv_col;
   logic [ADDR_W-1:0]   offset;

   assign trigger   = btn_sync_q & ~btn_prev_q;
   assign last_elem = (row_q == IDX_LAST) && (col_q == IDX_LAST);
   assign adv_col   = (col_q == IDX_LAST) ? 4'd0 : col_q + 4'd1;
   assign adv_row   = (col_q == IDX_LAST) ? row_q + 4'd1 : row_q;
   assign offset    = ADDR_W'(row_q) * N_A + ADDR_W'(col_q);

   assign elem_row  = row_q;
   assign elem_col  = col_q;
   assign error     = error_q;
   assign busy      = (state_q != S_IDLE);
   assign state_dbg = state_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         src_q       <= '0;
         dst_q       <= '0;
         row_q       <= '0;
         col_q       <= '0;
         cnt_q       <= '0;
         mac_first_q <= 1'b0;
         error_q     <= 1'b0;
         btn_meta_q  <= 1'b0;
         btn_sync_q  <= 1'b0;
         btn_prev_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         src_q       <= src_d;
         dst_q       <= dst_d;
         row_q       <= row_d;
         col_q       <= col_d;
         cnt_q       <= cnt_d;
         mac_first_q <= mac_first_d;
         error_q     <= error_d;
         btn_meta_q  <= start_btn;
         btn_sync_q  <= btn_meta_q;
         btn_prev_q  <= btn_sync_q;
      end
   end

   always_comb begin
      state_d     = state_q;
      src_d       = src_q;
      dst_d       = dst_q;
      row_d       = row_q;
      col_d       = col_q;
      cnt_d       = cnt_q;
      mac_first_d = mac_first_q;
      error_d     = error_q;
      mem_addr    = '0;
      mem_rd_en   = 1'b0;
      mem_wr_en   = 1'b0;
      load_we     = 1'b0;
      mac_start   = 1'b0;
      act_en      = 1'b0;
      norm_en     = 1'b0;
      done        = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (trigger) begin
               src_d   = src_base;
               dst_d   = dst_base;
               error_d = 1'b0;
               row_d   = '0;
               col_d   = '0;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            // Single outstanding read: the request stays up until its data returns.
            mem_addr = src_q + offset;
            if (mem_rd_valid) begin
               load_we = 1'b1;
               if (last_elem) begin
                  mac_first_d = 1'b1;
                  state_d     = S_MAC;
               end else begin
                  row_d = adv_row;
                  col_d = adv_col;
               end
            end else begin
               mem_rd_en = 1'b1;
            end
         end
         S_MAC: begin
            if (mac_first_q) begin
               mac_start   = 1'b1;
               mac_first_d = 1'b0;
               cnt_d       = '0;
            end else if (mac_done) begin
               cnt_d   = '0;
               state_d = S_ACT;
            end else if (cnt_q == MAC_LAST) begin
               cnt_d   = '0;
               error_d = 1'b1;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_ACT: begin
            act_en = 1'b1;
            if (cnt_q == ACT_LAST) begin
               cnt_d   = '0;
               state_d = S_NORM;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_NORM: begin
            norm_en = 1'b1;
            if (cnt_q == NORM_LAST) begin
               cnt_d   = '0;
               row_d   = '0;
               col_d   = '0;
               state_d = S_STORE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_STORE: begin
            mem_wr_en = 1'b1;
            mem_addr  = dst_q + offset;
            if (last_elem) begin
               state_d = S_DONE;
            end else begin
               row_d = adv_row;
               col_d = adv_col;
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_npu_layer_sequencer.sv
// Self-checking bench for npu_layer_sequencer: RAM and MAC responders plus a load/store scoreboard.
module tb_npu_layer_sequencer;

   localparam int N           = 10;
   localparam int ADDR_W      = 16;
   localparam int ACT_LAT     = 1;
   localparam int NORM_LAT    = 2;
   localparam int MAC_TIMEOUT = 1023;
   localparam int M_LAT       = 30;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_btn = 1'b0;
   logic [15:0] src_base = '0;
   logic [15:0] dst_base = '0;
   logic        mem_rd_valid = 1'b0;
   logic        mac_done = 1'b0;
   logic [15:0] mem_addr;
   logic        mem_rd_en, mem_wr_en, load_we, mac_start, act_en, norm_en;
   logic        busy, done, error;
   logic [3:0]  elem_row, elem_col;
   logic [2:0]  state_dbg;

   int n_err = 0;
   int n_chk = 0;
   int ram_lat = 1;
   int mac_lat = M_LAT;

   npu_layer_sequencer #(
      .N(N), .ADDR_W(ADDR_W), .ACT_LAT(ACT_LAT), .NORM_LAT(NORM_LAT), .MAC_TIMEOUT(MAC_TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .start_btn(start_btn), .src_base(src_base), .dst_base(dst_base),
      .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rd_valid(mem_rd_valid),
      .mem_wr_en(mem_wr_en), .elem_row(elem_row), .elem_col(elem_col), .load_we(load_we),
      .mac_start(mac_start), .mac_done(mac_done), .act_en(act_en), .norm_en(norm_en),
      .busy(busy), .done(done), .error(error), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   // RAM: data valid ram_lat cycles after the first cycle of a request.
   bit   rd_pend = 1'b0;
   int   rd_cnt = 0;
   logic rd_en_s, rd_vld_s;
   always begin
      @(negedge clk);
      rd_en_s  = mem_rd_en;
      rd_vld_s = mem_rd_valid;
      @(posedge clk);
      #1;
      if (rst || rd_vld_s) begin
         rd_pend      = 1'b0;
         mem_rd_valid = 1'b0;
      end else begin
         if (rd_en_s && !rd_pend) begin
            rd_pend = 1'b1;
            rd_cnt  = 1;
         end else if (rd_pend) begin
            rd_cnt++;
         end
         if (rd_pend && rd_cnt == ram_lat) mem_rd_valid = 1'b1;
      end
   end

   // MAC array: one-cycle done pulse mac_lat cycles after mac_start (0 = never).
   bit   mac_arm = 1'b0;
   int   mac_cnt_r = 0;
   logic ms_s;
   always begin
      @(negedge clk);
      ms_s = mac_start;
      @(posedge clk);
      #1;
      mac_done = 1'b0;
      if (rst) mac_arm = 1'b0;
      else if (ms_s) begin
         mac_arm   = 1'b1;
         mac_cnt_r = 1;
      end else if (mac_arm) mac_cnt_r++;
      if (mac_arm && mac_lat > 0 && mac_cnt_r == mac_lat) begin
         mac_done = 1'b1;
         mac_arm  = 1'b0;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation still running, required completion");
      $fatal(1, "watchdog expired");
   end

   logic [15:0] exp_ld_addr_q[$];
   int          exp_rc_q[$];
   logic [15:0] exp_wr_addr_q[$];
   logic [15:0] act_ld_addr_q[$];
   int          act_rc_q[$];
   int          act_run_q[$];
   logic [15:0] act_wr_addr_q[$];

   int          ld_cnt, wr_cnt, mac_cnt, act_cyc, norm_cyc, done_cnt, overlap, busy_again;
   int          busy_first, mac_cyc, done_cyc, err_cyc;
   bit          timed_out, err_at_busy;
   logic [15:0] last_wr_addr;

   task automatic push_expected(input logic [15:0] src, input logic [15:0] dst);
      exp_ld_addr_q.delete();
      exp_rc_q.delete();
      exp_wr_addr_q.delete();
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) begin
            exp_ld_addr_q.push_back(src + 16'(r * N + c));
            exp_rc_q.push_back(r * 16 + c);
            exp_wr_addr_q.push_back(dst + 16'(r * N + c));
         end
      end
   endtask

   // Presses the button for 5 cycles and records everything the DUT does until it has been idle 20 cycles.
   task automatic observe(input int max_cyc, input int press2_cyc, input int stop_wr);
      int rd_run = 0;
      int tail = 0;
      bit seen_busy = 1'b0;
      bit fin = 1'b0;
      bit prev_err;
      act_ld_addr_q.delete();
      act_rc_q.delete();
      act_run_q.delete();
      act_wr_addr_q.delete();
      ld_cnt = 0; wr_cnt = 0; mac_cnt = 0; act_cyc = 0; norm_cyc = 0;
      done_cnt = 0; overlap = 0; busy_again = 0;
      busy_first = -1; mac_cyc = -1; done_cyc = -1; err_cyc = -1;
      timed_out = 1'b1; err_at_busy = 1'b0; last_wr_addr = '0;
      @(negedge clk);
      prev_err  = error;
      start_btn = 1'b1;
      for (int cyc = 0; cyc < max_cyc && !fin; cyc++) begin
         @(negedge clk);
         if (busy && !seen_busy) begin
            seen_busy   = 1'b1;
            busy_first  = cyc;
            err_at_busy = error;
         end else if (busy && tail > 0) begin
            busy_again++;
         end
         if (mem_rd_en) rd_run++;
         if (load_we) begin
            ld_cnt++;
            act_ld_addr_q.push_back(mem_addr);
            act_rc_q.push_back(int'(elem_row) * 16 + int'(elem_col));
            act_run_q.push_back(rd_run);
            rd_run = 0;
         end
         if (int'(mem_rd_en) + int'(mem_wr_en) + int'(load_we) > 1) overlap++;
         if (mac_start) begin
            mac_cnt++;
            mac_cyc = cyc;
         end
         if (act_en) act_cyc++;
         if (norm_en) norm_cyc++;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (error && !prev_err) err_cyc = cyc;
         prev_err = error;
         if (mem_wr_en) begin
            wr_cnt++;
            last_wr_addr = mem_addr;
            act_wr_addr_q.push_back(mem_addr);
            if (stop_wr > 0 && wr_cnt == stop_wr) begin
               fin       = 1'b1;
               timed_out = 1'b0;
            end
         end
         if (seen_busy && !busy) begin
            tail++;
            if (tail >= 20) begin
               fin       = 1'b1;
               timed_out = 1'b0;
            end
         end
         if (cyc == 4) start_btn = 1'b0;
         if (press2_cyc > 0 && cyc == press2_cyc) start_btn = 1'b1;
         if (press2_cyc > 0 && cyc == press2_cyc + 4) start_btn = 1'b0;
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_chk++;
      if ({mem_rd_en, mem_wr_en, load_we, mac_start, act_en, norm_en, busy, done, error} !== 9'b0) begin
         n_err++;
         $display("FAIL reset_strobes: got %b, expected 000000000",
                  {mem_rd_en, mem_wr_en, load_we, mac_start, act_en, norm_en, busy, done, error});
      end
      n_chk++;
      if (mem_addr !== 16'h0 || elem_row !== 4'h0 || elem_col !== 4'h0 || state_dbg !== 3'd0) begin
         n_err++;
         $display("FAIL reset_values: got addr=%h row=%0d col=%0d state=%0d, expected all 0",
                  mem_addr, elem_row, elem_col, state_dbg);
      end
      rst = 1'b0;
      repeat (4) @(negedge clk);
      n_chk++;
      if (busy !== 1'b0 || state_dbg !== 3'd0) begin
         n_err++;
         $display("FAIL reset_idle: got busy=%b state=%0d, expected busy=0 state=0", busy, state_dbg);
      end
   endtask

   task automatic test_basic();
      logic [15:0] e_a, a_a;
      int e_rc, a_rc;
      int k = 0;
      ram_lat = 1; mac_lat = M_LAT;
      src_base = 16'h1000; dst_base = 16'h2000;
      push_expected(src_base, dst_base);
      observe(2000, 0, 0);
      n_chk++;
      if (timed_out) begin n_err++; $display("FAIL basic_timeout: pass never finished, expected completion"); end
      while (exp_ld_addr_q.size() > 0) begin
         e_a = exp_ld_addr_q.pop_front();
         e_rc = exp_rc_q.pop_front();
         n_chk++;
         if (act_ld_addr_q.size() == 0) begin
            n_err++;
            $display("FAIL basic_load[%0d]: got no load_we, expected addr=%h", k, e_a);
         end else begin
            a_a = act_ld_addr_q.pop_front();
            a_rc = act_rc_q.pop_front();
            if (a_a !== e_a || a_rc !== e_rc) begin
               n_err++;
               $display("FAIL basic_load[%0d]: got addr=%h rc=%0h, expected addr=%h rc=%0h", k, a_a, a_rc, e_a, e_rc);
            end
         end
         k++;
      end
      k = 0;
      while (exp_wr_addr_q.size() > 0) begin
         e_a = exp_wr_addr_q.pop_front();
         n_chk++;
         if (act_wr_addr_q.size() == 0) begin
            n_err++;
            $display("FAIL basic_store[%0d]: got no write, expected addr=%h", k, e_a);
         end else begin
            a_a = act_wr_addr_q.pop_front();
            if (a_a !== e_a) begin
               n_err++;
               $display("FAIL basic_store[%0d]: got addr=%h, expected addr=%h", k, a_a, e_a);
            end
         end
         k++;
      end
      n_chk++;
      if (ld_cnt !== N * N || wr_cnt !== N * N) begin
         n_err++;
         $display("FAIL basic_counts: got loads=%0d writes=%0d, expected %0d each", ld_cnt, wr_cnt, N * N);
      end
      n_chk++;
      if (mac_cnt !== 1 || act_cyc !== ACT_LAT || norm_cyc !== NORM_LAT) begin
         n_err++;
         $display("FAIL basic_phases: got mac_start=%0d act=%0d norm=%0d, expected 1/%0d/%0d",
                  mac_cnt, act_cyc, norm_cyc, ACT_LAT, NORM_LAT);
      end
      n_chk++;
      if (done_cnt !== 1 || busy !== 1'b0 || error !== 1'b0 || busy_again !== 0) begin
         n_err++;
         $display("FAIL basic_end: got done=%0d busy=%b error=%b rebusy=%0d, expected 1/0/0/0",
                  done_cnt, busy, error, busy_again);
      end
      // busy rises the cycle after the internal trigger, so one cycle less than trigger-to-done.
      n_chk++;
      if (done_cyc - busy_first !== 2 * N * N + 1 + M_LAT + ACT_LAT + NORM_LAT + N * N + 1 - 1) begin
         n_err++;
         $display("FAIL basic_latency: got %0d, expected %0d", done_cyc - busy_first,
                  2 * N * N + 1 + M_LAT + ACT_LAT + NORM_LAT + N * N);
      end
      n_chk++;
      if (overlap !== 0) begin n_err++; $display("FAIL basic_overlap: got %0d overlapping cycles, expected 0", overlap); end
   endtask

   task automatic test_wrap();
      logic [15:0] e_a, a_a;
      int k = 0;
      ram_lat = 1; mac_lat = M_LAT;
      src_base = 16'hFFF0; dst_base = 16'h0200;
      push_expected(src_base, dst_base);
      observe(2000, 0, 0);
      n_chk++;
      if (act_ld_addr_q.size() !== N * N) begin
         n_err++;
         $display("FAIL wrap_count: got %0d loads, expected %0d", act_ld_addr_q.size(), N * N);
      end else if (act_ld_addr_q[0] !== 16'hFFF0 || act_ld_addr_q[15] !== 16'hFFFF ||
                   act_ld_addr_q[16] !== 16'h0000 || act_ld_addr_q[99] !== 16'h0053) begin
         n_err++;
         $display("FAIL wrap_edges: got %h %h %h %h, expected fff0 ffff 0000 0053",
                  act_ld_addr_q[0], act_ld_addr_q[15], act_ld_addr_q[16], act_ld_addr_q[99]);
      end
      while (exp_ld_addr_q.size() > 0 && act_ld_addr_q.size() > 0) begin
         e_a = exp_ld_addr_q.pop_front();
         a_a = act_ld_addr_q.pop_front();
         n_chk++;
         if (a_a !== e_a) begin
            n_err++;
            $display("FAIL wrap_load[%0d]: got addr=%h, expected addr=%h", k, a_a, e_a);
         end
         k++;
      end
      n_chk++;
      if (done_cnt !== 1) begin n_err++; $display("FAIL wrap_done: got %0d done pulses, expected 1", done_cnt); end
   endtask

   task automatic test_slow_ram();
      int run;
      int k = 0;
      ram_lat = 3; mac_lat = M_LAT;
      src_base = 16'h0040; dst_base = 16'h0800;
      push_expected(src_base, dst_base);
      observe(3000, 0, 0);
      n_chk++;
      if (ld_cnt !== N * N || done_cnt !== 1 || overlap !== 0) begin
         n_err++;
         $display("FAIL slow_counts: got loads=%0d done=%0d overlap=%0d, expected %0d/1/0",
                  ld_cnt, done_cnt, overlap, N * N);
      end
      while (act_run_q.size() > 0) begin
         run = act_run_q.pop_front();
         n_chk++;
         if (run !== ram_lat) begin
            n_err++;
            $display("FAIL slow_rd_en[%0d]: got rd_en held %0d cycles, expected %0d", k, run, ram_lat);
         end
         k++;
      end
   endtask

   task automatic test_timeout();
      ram_lat = 1; mac_lat = 0;
      src_base = 16'h0100; dst_base = 16'h0500;
      push_expected(src_base, dst_base);
      observe(3000, 0, 0);
      n_chk++;
      if (timed_out || error !== 1'b1 || busy !== 1'b0 || state_dbg !== 3'd0) begin
         n_err++;
         $display("FAIL timeout_exit: got hung=%b error=%b busy=%b state=%0d, expected 0/1/0/0",
                  timed_out, error, busy, state_dbg);
      end
      // mac_start cycle plus MAC_TIMEOUT cycles of waiting, error visible on the following cycle.
      n_chk++;
      if (err_cyc - mac_cyc !== MAC_TIMEOUT + 1) begin
         n_err++;
         $display("FAIL timeout_cycles: got %0d, expected %0d", err_cyc - mac_cyc, MAC_TIMEOUT + 1);
      end
      n_chk++;
      if (wr_cnt !== 0 || done_cnt !== 0 || act_cyc !== 0 || mac_cnt !== 1) begin
         n_err++;
         $display("FAIL timeout_phases: got writes=%0d done=%0d act=%0d mac_start=%0d, expected 0/0/0/1",
                  wr_cnt, done_cnt, act_cyc, mac_cnt);
      end
   endtask

   task automatic test_error_clear();
      ram_lat = 1; mac_lat = M_LAT;
      observe(2000, 0, 0);
      n_chk++;
      if (err_at_busy !== 1'b0 || error !== 1'b0 || done_cnt !== 1) begin
         n_err++;
         $display("FAIL error_clear: got error@start=%b error=%b done=%0d, expected 0/0/1",
                  err_at_busy, error, done_cnt);
      end
   endtask

   task automatic test_back_to_back();
      ram_lat = 1; mac_lat = M_LAT;
      src_base = 16'h3000; dst_base = 16'h4000;
      observe(2000, 205, 0);
      n_chk++;
      if (mac_cyc < 0 || mac_cyc >= 207 || done_cyc <= 207) begin
         n_err++;
         $display("FAIL b2b_window: got mac_start@%0d done@%0d, expected second trigger (207) inside MAC",
                  mac_cyc, done_cyc);
      end
      n_chk++;
      if (done_cnt !== 1 || mac_cnt !== 1 || busy_again !== 0 || ld_cnt !== N * N) begin
         n_err++;
         $display("FAIL b2b_single: got done=%0d mac_start=%0d rebusy=%0d loads=%0d, expected 1/1/0/%0d",
                  done_cnt, mac_cnt, busy_again, ld_cnt, N * N);
      end
   endtask

   task automatic test_reset_abort();
      ram_lat = 1; mac_lat = M_LAT;
      src_base = 16'h0300; dst_base = 16'h0400;
      push_expected(src_base, dst_base);
      observe(2000, 0, 41);
      n_chk++;
      if (timed_out || wr_cnt !== 41 || last_wr_addr !== exp_wr_addr_q[40]) begin
         n_err++;
         $display("FAIL abort_reach: got writes=%0d addr=%h, expected 41 and %h", wr_cnt, last_wr_addr, exp_wr_addr_q[40]);
      end
      rst = 1'b1;
      #1;
      n_chk++;
      if ({mem_rd_en, mem_wr_en, load_we, mac_start, act_en, norm_en, busy, done, error} !== 9'b0 ||
          mem_addr !== 16'h0 || elem_row !== 4'h0 || elem_col !== 4'h0 || state_dbg !== 3'd0) begin
         n_err++;
         $display("FAIL abort_outputs: got wr=%b busy=%b done=%b addr=%h row=%0d col=%0d state=%0d, expected all 0",
                  mem_wr_en, busy, done, mem_addr, elem_row, elem_col, state_dbg);
      end
      @(negedge clk);
      n_chk++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL abort_hold: got done=%b busy=%b, expected 0/0", done, busy);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      push_expected(src_base, dst_base);
      observe(2000, 0, 0);
      n_chk++;
      if (act_ld_addr_q.size() == 0 || act_ld_addr_q[0] !== exp_ld_addr_q[0] || act_rc_q[0] !== 0) begin
         n_err++;
         $display("FAIL abort_restart: got %0d loads, first addr=%h, expected first addr=%h at (0,0)",
                  act_ld_addr_q.size(), (act_ld_addr_q.size() > 0) ? act_ld_addr_q[0] : 16'h0, exp_ld_addr_q[0]);
      end
      n_chk++;
      if (done_cnt !== 1 || ld_cnt !== N * N || wr_cnt !== N * N) begin
         n_err++;
         $display("FAIL abort_rerun: got done=%0d loads=%0d writes=%0d, expected 1/%0d/%0d",
                  done_cnt, ld_cnt, wr_cnt, N * N, N * N);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_slow_ram();
      test_timeout();
      test_error_clear();
      test_back_to_back();
      test_reset_abort();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
